salamander_irq_ctrl: RTL and testbench

- Parametrised interrupt controller for the 68000 main CPU. It generalises the fixed two-source VBLANK/frame-parity IPL logic to NCH sources.
- Each source has a configurable IPL level, edge or level sensing, enable and pending registers, and auto-clear on the CPU IACK cycle.
- It sits between the video timing/peripheral sources and the fx68k IPL inputs. The main address decoder gives it a 4-byte register window.

---
 rtl/salamander_irq_ctrl.sv | 148 ++++++++++++++
 tb/tb_salamander_irq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/salamander_irq_ctrl.sv
// salamander_irq_ctrl: NCH-source interrupt controller driving the 68000 IPL lines.
// Sources are synchronised, edge/level qualified into PENDING, masked by ENABLE/GEN,
// priority-encoded to the highest IPL level and auto-cleared on the IACK cycle.
module salamander_irq_ctrl #(
    parameter int               NCH         = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [3*NCH-1:0] IPL_MAP     = {3'd4, 3'd3, 3'd2, 3'd1},
    parameter logic [NCH-1:0]   EDGE_MASK   = {NCH{1'b1}}
) (
    input  logic           i_EMU_MCLK,
    input  logic           i_EMU_INITRST_n,
    input  logic           i_EMU_SOFTRST_n,
    input  logic [NCH-1:0] i_IRQ_SRC,
    input  logic           i_REG_CS,
    input  logic           i_REG_WR,
    input  logic           i_REG_LDS_n,
    input  logic [1:0]     i_REG_ADDR,
    input  logic [7:0]     i_REG_DI,
    output logic [7:0]     o_REG_DO,
    input  logic           i_IACK,
    input  logic [2:0]     i_IACK_LVL,
    output logic [2:0]     o_IPL_n,
    output logic [NCH-1:0] o_PENDING
);

    logic [SYNC_STAGES-1:0][NCH-1:0] r_sync;
    logic [NCH-1:0] r_hist;
    logic [NCH-1:0] r_evt;
    logic [NCH-1:0] r_pending;
    logic [NCH-1:0] r_enable;
    logic           r_autoack;
    logic           r_gen;
    logic           r_iack_q;
    logic [2:0]     r_lvl_q;

    logic [NCH-1:0] w_sync;
    logic [NCH-1:0] w_edge;
    logic [NCH-1:0] w_set;
    logic [NCH-1:0] w_w1c;
    logic [NCH-1:0] w_force;
    logic [NCH-1:0] w_active;
    logic [NCH-1:0] w_iack_clr;
    logic           w_wr;
    logic           w_iack_ok;
    logic           w_hit;
    logic [2:0]     w_lvl;
    logic           w_unused;

    // Upper data bits are ignored when NCH < 8.
    assign w_unused = &{1'b0, i_REG_DI};

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_edge  = w_sync & ~r_hist;
    // Edge channels set on a rising edge, level channels on every high cycle.
    assign w_set   = (EDGE_MASK & w_edge) | (~EDGE_MASK & w_sync);

    assign w_wr    = i_REG_CS & i_REG_WR & ~i_REG_LDS_n;
    assign w_w1c   = (w_wr && i_REG_ADDR == 2'd1) ? i_REG_DI[NCH-1:0] : '0;
    assign w_force = (w_wr && i_REG_ADDR == 2'd2) ? i_REG_DI[NCH-1:0] : '0;

    assign w_active  = r_gen ? (r_pending & r_enable) : '0;
    // Only the first cycle of an IACK that matches the presented level may clear.
    assign w_iack_ok = i_IACK & ~r_iack_q & r_autoack &
                       (i_IACK_LVL == r_lvl_q) & (r_lvl_q != 3'd0);

    // Synchroniser chain, edge history and registered set events per source.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            r_sync <= '0;
            r_hist <= '0;
            r_evt  <= '0;
        end else if (!i_EMU_SOFTRST_n) begin
            r_sync <= '0;
            r_hist <= '0;
            r_evt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_IRQ_SRC};
            r_hist <= w_sync;
            r_evt  <= w_set;
        end
    end

    // Highest IPL level among active channels; level-0 channels never win.
    always_comb begin
        w_lvl = 3'd0;
        for (int k = 0; k < NCH; k++) begin
            if (w_active[k] && (IPL_MAP[3*k +: 3] > w_lvl))
                w_lvl = IPL_MAP[3*k +: 3];
        end
    end

    // Lowest-index active channel at the acknowledged level is the one cleared.
    always_comb begin
        w_iack_clr = '0;
        w_hit      = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_hit && w_active[k] && (IPL_MAP[3*k +: 3] == r_lvl_q)) begin
                w_iack_clr[k] = w_iack_ok;
                w_hit         = 1'b1;
            end
        end
    end

    // Pending/enable/control registers, registered IPL level and IACK history.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_autoack <= 1'b0;
            r_gen     <= 1'b1;
            r_lvl_q   <= 3'd0;
            r_iack_q  <= 1'b0;
        end else if (!i_EMU_SOFTRST_n) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_autoack <= 1'b0;
            r_gen     <= 1'b1;
            r_lvl_q   <= 3'd0;
            r_iack_q  <= 1'b0;
        end else begin
            // Sets are OR-ed in after the clears so a coincident set always wins.
            r_pending <= (r_pending & ~(w_w1c | w_iack_clr)) | w_force | r_evt;
            if (w_wr && i_REG_ADDR == 2'd0)
                r_enable <= i_REG_DI[NCH-1:0];
            if (w_wr && i_REG_ADDR == 2'd3) begin
                r_autoack <= i_REG_DI[0];
                r_gen     <= i_REG_DI[1];
            end
            r_lvl_q  <= w_lvl;
            r_iack_q <= i_IACK;
        end
    end

    // Register read mux; unimplemented bits read as zero.
    always_comb begin
        o_REG_DO = 8'h00;
        case (i_REG_ADDR)
            2'd0:    o_REG_DO[NCH-1:0] = r_enable;
            2'd1:    o_REG_DO[NCH-1:0] = r_pending;
            2'd2:    o_REG_DO[NCH-1:0] = w_sync;
            default: o_REG_DO[1:0]     = {r_gen, r_autoack};
        endcase
    end

    assign o_IPL_n   = ~r_lvl_q;
    assign o_PENDING = r_pending;

endmodule

// File: tb/tb_salamander_irq_ctrl.sv
// Directed bench for salamander_irq_ctrl with channel 3 configured for level sensing.
module tb_salamander_irq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       soft_n;
    logic [3:0] src;
    logic       cs;
    logic       wr;
    logic       lds_n;
    logic [1:0] addr;
    logic [7:0] di;
    logic [7:0] dout;
    logic       iack;
    logic [2:0] iack_lvl;
    logic [2:0] ipl_n;
    logic [3:0] pend;

    int n_chk;
    int n_pass;

    salamander_irq_ctrl #(
        .NCH        (4),
        .SYNC_STAGES(2),
        .IPL_MAP    ({3'd4, 3'd3, 3'd2, 3'd1}),
        .EDGE_MASK  (4'b0111)
    ) u_dut (
        .i_EMU_MCLK     (clk),
        .i_EMU_INITRST_n(rst_n),
        .i_EMU_SOFTRST_n(soft_n),
        .i_IRQ_SRC      (src),
        .i_REG_CS       (cs),
        .i_REG_WR       (wr),
        .i_REG_LDS_n    (lds_n),
        .i_REG_ADDR     (addr),
        .i_REG_DI       (di),
        .o_REG_DO       (dout),
        .i_IACK         (iack),
        .i_IACK_LVL     (iack_lvl),
        .o_IPL_n        (ipl_n),
        .o_PENDING      (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; lds_n = 1'b0; addr = a; di = d;
        tick();
        cs = 1'b0; wr = 1'b0; lds_n = 1'b1; di = 8'h00;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic pulse(input logic [3:0] m);
        src = src | m;
        tick();
        src = src & ~m;
    endtask

    logic [7:0] v;

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; soft_n = 1'b1; src = 4'h0;
        cs = 1'b0; wr = 1'b0; lds_n = 1'b1; addr = 2'd0; di = 8'h00;
        iack = 1'b0; iack_lvl = 3'd0;
        repeat (3) tick();

        // Reset state
        chk("rst_ipl", {5'd0, ipl_n}, 8'h07);
        rd_reg(2'd3, v); chk("rst_ctrl", v, 8'h02);
        rd_reg(2'd1, v); chk("rst_pend", v, 8'h00);
        rd_reg(2'd0, v); chk("rst_en", v, 8'h00);
        rst_n = 1'b1;
        tick();

        // Single edge on src[1]: pending after 3 edges, IPL exactly 4 edges after sampling
        wr_reg(2'd0, 8'h0F);
        rd_reg(2'd0, v); chk("en_rw", v, 8'h0F);
        pulse(4'b0010);
        repeat (3) tick();
        chk("p1_pend", {4'd0, pend}, 8'h02);
        chk("p1_ipl_early", {5'd0, ipl_n}, 8'h07);
        tick();
        chk("p1_ipl", {5'd0, ipl_n}, 8'h05);
        wr_reg(2'd1, 8'h02);
        rd_reg(2'd1, v); chk("w1c_pend", v, 8'h00);
        chk("w1c_ipl_lag", {5'd0, ipl_n}, 8'h05);
        tick();
        chk("w1c_ipl", {5'd0, ipl_n}, 8'h07);

        // Two channels pending, IACK auto-clear of the level-3 channel
        pulse(4'b0101);
        repeat (3) tick();
        chk("p02_pend", {4'd0, pend}, 8'h05);
        tick();
        chk("p02_ipl", {5'd0, ipl_n}, 8'h04);
        wr_reg(2'd3, 8'h03);
        iack = 1'b1; iack_lvl = 3'd3;
        tick();
        chk("iack3_pend", {4'd0, pend}, 8'h01);
        tick();
        chk("iack3_ipl", {5'd0, ipl_n}, 8'h06);
        iack = 1'b0;
        tick();
        iack = 1'b1; iack_lvl = 3'd2;
        tick();
        chk("iack_mis_pend", {4'd0, pend}, 8'h01);
        chk("iack_mis_ipl", {5'd0, ipl_n}, 8'h06);
        iack = 1'b0;
        tick();

        // Held IACK clears only on its first cycle
        iack = 1'b1; iack_lvl = 3'd1;
        tick();
        chk("iack1_pend", {4'd0, pend}, 8'h00);
        pulse(4'b0001);
        repeat (3) tick();
        tick();
        chk("iack_held_ipl", {5'd0, ipl_n}, 8'h06);
        tick();
        chk("iack_once", {4'd0, pend}, 8'h01);
        iack = 1'b0;
        tick();
        wr_reg(2'd1, 8'h01);
        tick();
        chk("clean_ipl", {5'd0, ipl_n}, 8'h07);

        // Edge event landing on the same edge as a W1C of that bit
        pulse(4'b0010);
        repeat (3) tick();
        pulse(4'b0010);
        repeat (2) tick();
        wr_reg(2'd1, 8'h02);
        chk("set_wins", {4'd0, pend}, 8'h02);
        wr_reg(2'd1, 8'h02);
        chk("w1c_after", {4'd0, pend}, 8'h00);
        tick();

        // Level channel 3 held high re-asserts through W1C
        wr_reg(2'd0, 8'h08);
        src = 4'b1000;
        repeat (5) tick();
        chk("lvl_pend", {4'd0, pend}, 8'h08);
        chk("lvl_ipl", {5'd0, ipl_n}, 8'h03);
        wr_reg(2'd1, 8'h08);
        chk("lvl_w1c_pend", {4'd0, pend}, 8'h08);
        tick();
        chk("lvl_w1c_ipl", {5'd0, ipl_n}, 8'h03);
        src = 4'b0000;
        repeat (4) tick();
        wr_reg(2'd1, 8'h08);
        chk("lvl_rel_pend", {4'd0, pend}, 8'h00);
        tick();
        chk("lvl_rel_ipl", {5'd0, ipl_n}, 8'h07);

        // FORCE read-back returns synchronised source levels
        src = 4'b1010;
        repeat (2) tick();
        rd_reg(2'd2, v); chk("sync_read", v, 8'h0A);
        src = 4'b0000;

        // Global enable gating and FORCE set
        wr_reg(2'd0, 8'h0F);
        wr_reg(2'd3, 8'h01);
        wr_reg(2'd2, 8'h0F);
        chk("force_pend", {4'd0, pend}, 8'h0F);
        tick();
        chk("gen0_ipl", {5'd0, ipl_n}, 8'h07);
        wr_reg(2'd3, 8'h03);
        chk("gen1_lag", {5'd0, ipl_n}, 8'h07);
        tick();
        chk("gen1_ipl", {5'd0, ipl_n}, 8'h03);
        wr_reg(2'd1, 8'h0F);
        wr_reg(2'd0, 8'h01);
        wr_reg(2'd2, 8'h01);
        chk("force1_pend", {4'd0, pend}, 8'h01);
        tick();
        chk("force1_ipl", {5'd0, ipl_n}, 8'h06);

        // Asynchronous reset mid-cycle
        wr_reg(2'd0, 8'h0F);
        wr_reg(2'd2, 8'h0F);
        tick();
        chk("pre_arst_ipl", {5'd0, ipl_n}, 8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ipl", {5'd0, ipl_n}, 8'h07);
        chk("arst_pend", {4'd0, pend}, 8'h00);
        rd_reg(2'd3, v); chk("arst_ctrl", v, 8'h02);
        rd_reg(2'd0, v); chk("arst_en", v, 8'h00);
        rst_n = 1'b1;
        tick();

        // Synchronous soft reset
        wr_reg(2'd0, 8'h0F);
        wr_reg(2'd2, 8'h0F);
        tick();
        chk("pre_srst_ipl", {5'd0, ipl_n}, 8'h03);
        soft_n = 1'b0;
        #2;
        chk("srst_wait_ipl", {5'd0, ipl_n}, 8'h03);
        tick();
        chk("srst_ipl", {5'd0, ipl_n}, 8'h07);
        chk("srst_pend", {4'd0, pend}, 8'h00);
        rd_reg(2'd3, v); chk("srst_ctrl", v, 8'h02);
        rd_reg(2'd0, v); chk("srst_en", v, 8'h00);
        soft_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
